ysyx_25060170_idu_stage: RTL and testbench
==========================================

// Module: ysyx_25060170_idu_stage
// PURPOSE
//  Registered, handshaked RV32I/E decode stage between IFU and EXU. Accepts one fetched instruction per cycle,
//  reads the register file, and decodes full-ISA control, rd and immediate. Holds the result in a 2-entry
//  output buffer (main + skid) so EXU back-pressure never loses an instruction. Supports pipeline flush.
// PARAMETERS
//  XLEN       32  data/address width
//  REG_AW     5   register address width; 5 = RV32I, 4 = RV32E (rs1/rs2/rd bit 4 set -> illegal)
//  ALU_OP_W   4   width of the alu_op_o encoding (enumeration in shared package)
// PORTS
//  clk           in   1         clock
//  rst           in   1         reset, asynchronous, active-high
//  in_valid_i    in   1         IFU offers inst_i/inst_addr_i
//  in_ready_o    out  1         stage can accept (= !skid_valid)
//  inst_i        in   32        instruction word
//  inst_addr_i   in   XLEN      instruction PC
//  flush_i       in   1         drop all buffered and incoming instructions
//  reg1_raddr_o  out  REG_AW    regfile read addr 1 = inst_i[15+:REG_AW], combinational
//  reg2_raddr_o  out  REG_AW    regfile read addr 2 = inst_i[20+:REG_AW], combinational
//  reg1_rdata_i  in   XLEN      regfile read data 1 (same-cycle)
//  reg2_rdata_i  in   XLEN      regfile read data 2 (same-cycle)
//  out_valid_o   out  1         decoded bundle valid to EXU
//  out_ready_i   in   1         EXU consumes bundle
//  inst_o, inst_addr_o  out 32/XLEN   registered copies
//  rs1_data_o, rs2_data_o out XLEN   operands (forced 0 when address is x0)
//  imm_o         out  XLEN      sign-extended I/S/B/U/J immediate, 0 for R-type
//  reg_waddr_o   out  REG_AW    rd; 0 when reg_we_o=0
//  reg_we_o      out  1         writes rd (never for rd=x0, store, branch, illegal)
//  alu_op_o      out  ALU_OP_W  ALU operation
//  alu_src1_pc_o out  1         operand A = PC (AUIPC, JAL, JALR link)
//  alu_src2_imm_o out 1         operand B = imm_o
//  mem_re_o, mem_we_o out 1     load / store
//  mem_size_o    out  3         funct3 of load/store (sign + size)
//  branch_o, jump_o out 1       conditional branch / JAL-JALR
//  illegal_o     out  1         unsupported opcode/funct3/funct7 or RV32E reg >15
// BEHAVIOUR
//  - Reset (async): out_valid_o=0, skid_valid=0, all registered payload outputs 0.
//  - Accept = in_valid_i & in_ready_o & !flush_i. Decode and operand capture happen in the accept cycle;
//    bundle visible on out_* the next cycle (latency 1).
//  - On accept: if main empty or out_ready_i -> load main; else -> load skid (in_ready_o drops next cycle).
//  - out_valid_o & out_ready_i & skid_valid & no accept -> skid moves to main. Order is strictly FIFO.
//  - Consume without refill -> out_valid_o=0 next cycle. Main held stable while out_valid_o & !out_ready_i.
//  - flush_i: next cycle out_valid_o=0, skid_valid=0; incoming instruction same cycle is dropped.
//    Flush has priority over accept and consume.
//  - Illegal instructions still propagate with out_valid_o=1, illegal_o=1, reg_we_o=0, mem_we_o=0.
//  - Immediates: I=ins[31:20]; S={[31:25],[11:7]}; B={[31],[7],[30:25],[11:8],0};
//    U={[31:12],12'b0}; J={[31],[19:12],[20],[30:21],0}; sign-extended from bit 31 to XLEN.
//  - SYSTEM: ECALL/EBREAK decode legal, reg_we_o=0; FENCE treated as NOP.
//  - Operand data is sampled at accept; no forwarding (hazards are handled upstream).
// STRUCTURE
//  - Package ysyx_25060170_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR,
//    LUI, AUIPC, SYSTEM, MISC_MEM), alu_op enum, imm_type enum, decoded-bundle struct.
//  - Sub-module ysyx_25060170_imm_gen: combinational (inst, imm_type) -> imm.
//  - Top: combinational decoder + 2-entry main/skid register pair.
// TESTING
//  1 addi x1,x2,5 (0x00510093), reg2 data=7 -> next cycle valid, imm=5, rs1_data=7, waddr=1, we=1.
//  2 lui x5,0x12345 (0x123452B7) -> imm=0x12345000, waddr=5, alu_src2_imm=1, we=1.
//  3 sw x2,-4(x1) (0xFE20AE23) -> imm=0xFFFFFFFC, mem_we=1, mem_size=3'b010, we=0, waddr=0.
//  4 out_ready=0 for 3 cycles, 3 back-to-back inst -> 2 accepted, in_ready=0, 3rd held; release -> order kept.
//  5 0x00000000 -> illegal=1, we=0; REG_AW=4 with add x16,.. -> illegal=1.
//  6 flush with main+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1; rst mid-stream -> same.

Source files
------------

// File: rtl/ysyx_25060170_pkg.sv
// Shared decode definitions for the IDU stage: opcodes, ALU/immediate encodings, control bundle.
package ysyx_25060170_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB
    } alu_op_e;

    typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_type_e;

    typedef struct packed {
        logic       reg_we;
        alu_op_e    alu_op;
        logic       alu_src1_pc;
        logic       alu_src2_imm;
        logic       mem_re;
        logic       mem_we;
        logic [2:0] mem_size;
        logic       branch;
        logic       jump;
        logic       illegal;
    } dec_ctrl_t;

    // alt selects SUB/SRA; callers gate it so ADDI never turns into a subtract.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = AluAdd;
        unique case (funct3)
            3'd0: op = alt ? AluSub : AluAdd;
            3'd1: op = AluSll;
            3'd2: op = AluSlt;
            3'd3: op = AluSltu;
            3'd4: op = AluXor;
            3'd5: op = alt ? AluSra : AluSrl;
            3'd6: op = AluOr;
            3'd7: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ysyx_25060170_idu_stage_imm_gen.sv
// Immediate generator: selects the I/S/B/U/J field layout and sign-extends to XLEN.
module ysyx_25060170_imm_gen
    import ysyx_25060170_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     inst_i,
    input  imm_type_e       imm_type_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_type_i)
            ImmI:    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            ImmS:    imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            ImmB:    imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                              inst_i[11:8], 1'b0};
            ImmU:    imm32 = {inst_i[31:12], 12'b0};
            ImmJ:    imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                              inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/ysyx_25060170_idu_stage.sv
// RV32I/E decode stage: combinational decode plus a main/skid output buffer with flush.
module ysyx_25060170_idu_stage
    import ysyx_25060170_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         inst_i,
    input  logic [XLEN-1:0]     inst_addr_i,
    input  logic                flush_i,
    output logic [REG_AW-1:0]   reg1_raddr_o,
    output logic [REG_AW-1:0]   reg2_raddr_o,
    input  logic [XLEN-1:0]     reg1_rdata_i,
    input  logic [XLEN-1:0]     reg2_rdata_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [31:0]         inst_o,
    output logic [XLEN-1:0]     inst_addr_o,
    output logic [XLEN-1:0]     rs1_data_o,
    output logic [XLEN-1:0]     rs2_data_o,
    output logic [XLEN-1:0]     imm_o,
    output logic [REG_AW-1:0]   reg_waddr_o,
    output logic                reg_we_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                alu_src1_pc_o,
    output logic                alu_src2_imm_o,
    output logic                mem_re_o,
    output logic                mem_we_o,
    output logic [2:0]          mem_size_o,
    output logic                branch_o,
    output logic                jump_o,
    output logic                illegal_o
);

    typedef struct packed {
        logic [31:0]       inst;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] waddr;
        dec_ctrl_t         ctrl;
    } bundle_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            legal, rd_used, rs1_used, rs2_used, rv32e_bad;
    dec_ctrl_t       ctrl;
    imm_type_e       imm_type;
    logic [XLEN-1:0] imm;
    bundle_t         new_b, main_d, main_q, skid_d, skid_q;
    logic            valid_d, valid_q, skid_valid_d, skid_valid_q;
    logic            accept, consume;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    always_comb begin
        ctrl     = '0;
        imm_type = ImmNone;
        legal    = 1'b0;
        rd_used  = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            LUI: begin
                legal = 1'b1; rd_used = 1'b1; imm_type = ImmU;
                ctrl.alu_op = AluPassB; ctrl.alu_src2_imm = 1'b1;
            end
            AUIPC: begin
                legal = 1'b1; rd_used = 1'b1; imm_type = ImmU;
                ctrl.alu_src1_pc = 1'b1; ctrl.alu_src2_imm = 1'b1;
            end
            JAL: begin
                legal = 1'b1; rd_used = 1'b1; imm_type = ImmJ;
                ctrl.jump = 1'b1; ctrl.alu_src1_pc = 1'b1;
            end
            JALR: begin
                legal = (funct3 == 3'd0); rd_used = 1'b1; rs1_used = 1'b1; imm_type = ImmI;
                ctrl.jump = 1'b1; ctrl.alu_src1_pc = 1'b1;
            end
            BRANCH: begin
                legal = (funct3 != 3'd2) && (funct3 != 3'd3);
                rs1_used = 1'b1; rs2_used = 1'b1; imm_type = ImmB; ctrl.branch = 1'b1;
                ctrl.alu_op = !funct3[2] ? AluSub : (funct3[1] ? AluSltu : AluSlt);
            end
            LOAD: begin
                legal = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                rd_used = 1'b1; rs1_used = 1'b1; imm_type = ImmI;
                ctrl.mem_re = 1'b1; ctrl.alu_src2_imm = 1'b1; ctrl.mem_size = funct3;
            end
            STORE: begin
                legal = funct3 inside {3'd0, 3'd1, 3'd2};
                rs1_used = 1'b1; rs2_used = 1'b1; imm_type = ImmS;
                ctrl.mem_we = 1'b1; ctrl.alu_src2_imm = 1'b1; ctrl.mem_size = funct3;
            end
            OP_IMM: begin
                rd_used = 1'b1; rs1_used = 1'b1; imm_type = ImmI; ctrl.alu_src2_imm = 1'b1;
                ctrl.alu_op = alu_from_funct3(funct3, (funct3 == 3'd5) && funct7[5]);
                if (funct3 == 3'd1)      legal = (funct7 == 7'h00);
                else if (funct3 == 3'd5) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                else                     legal = 1'b1;
            end
            OP: begin
                rd_used = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
                ctrl.alu_op = alu_from_funct3(funct3, funct7[5]);
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
            end
            MISC_MEM: legal = (funct3 == 3'd0);
            SYSTEM:   legal = (inst_i[31:7] == '0) || (inst_i[31:7] == {12'h001, 13'b0});
            default:  legal = 1'b0;
        endcase

        // RV32E only has x0..x15: bit 4 of any register field the format uses is illegal.
        rv32e_bad = (REG_AW < 5) &&
                    ((rd_used && inst_i[11]) || (rs1_used && inst_i[19]) ||
                     (rs2_used && inst_i[24]));

        if (!legal || rv32e_bad) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            imm_type     = ImmNone;
        end else begin
            ctrl.reg_we = rd_used && (inst_i[7 +: REG_AW] != '0);
        end
    end

    ysyx_25060170_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .inst_i    (inst_i[31:7]),
        .imm_type_i(imm_type),
        .imm_o     (imm)
    );

    assign reg1_raddr_o = inst_i[15 +: REG_AW];
    assign reg2_raddr_o = inst_i[20 +: REG_AW];

    always_comb begin
        new_b       = '0;
        new_b.inst  = inst_i;
        new_b.addr  = inst_addr_i;
        new_b.rs1   = (reg1_raddr_o == '0) ? '0 : reg1_rdata_i;
        new_b.rs2   = (reg2_raddr_o == '0) ? '0 : reg2_rdata_i;
        new_b.imm   = imm;
        new_b.waddr = ctrl.reg_we ? inst_i[7 +: REG_AW] : '0;
        new_b.ctrl  = ctrl;
    end

    assign in_ready_o = !skid_valid_q;
    assign accept     = in_valid_i && in_ready_o && !flush_i;
    assign consume    = valid_q && out_ready_i;

    // accept implies the skid is empty, so skid promotion only happens without an accept.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        valid_d      = valid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            if (!valid_q || out_ready_i) begin
                main_d  = new_b;
                valid_d = 1'b1;
            end else begin
                skid_d       = new_b;
                skid_valid_d = 1'b1;
            end
        end else if (consume) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            valid_q      <= valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid_o    = valid_q;
    assign inst_o         = main_q.inst;
    assign inst_addr_o    = main_q.addr;
    assign rs1_data_o     = main_q.rs1;
    assign rs2_data_o     = main_q.rs2;
    assign imm_o          = main_q.imm;
    assign reg_waddr_o    = main_q.waddr;
    assign reg_we_o       = main_q.ctrl.reg_we;
    assign alu_op_o       = ALU_OP_W'(main_q.ctrl.alu_op);
    assign alu_src1_pc_o  = main_q.ctrl.alu_src1_pc;
    assign alu_src2_imm_o = main_q.ctrl.alu_src2_imm;
    assign mem_re_o       = main_q.ctrl.mem_re;
    assign mem_we_o       = main_q.ctrl.mem_we;
    assign mem_size_o     = main_q.ctrl.mem_size;
    assign branch_o       = main_q.ctrl.branch;
    assign jump_o         = main_q.ctrl.jump;
    assign illegal_o      = main_q.ctrl.illegal;

endmodule

// File: tb/tb_ysyx_25060170_idu_stage.sv
// Bench for the IDU stage: decode vector table, buffer corner sequences, random run vs. FIFO model.
`timescale 1ns/1ps
module tb_ysyx_25060170_idu_stage;
    import ysyx_25060170_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] inst, inst_addr, rdata1, rdata2, inst_o, inst_addr_o, rs1_o, rs2_o, imm_o;
    logic [4:0]  raddr1, raddr2, waddr_o;
    logic        we_o, src1pc_o, src2imm_o, mre_o, mwe_o, br_o, jmp_o, ill_o;
    logic [3:0]  alu_o;
    logic [2:0]  msize_o;
    logic [31:0] regs [32];

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    ysyx_25060170_idu_stage #(.XLEN(32), .REG_AW(5), .ALU_OP_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .inst_i(inst),
        .inst_addr_i(inst_addr), .flush_i(flush), .reg1_raddr_o(raddr1), .reg2_raddr_o(raddr2),
        .reg1_rdata_i(rdata1), .reg2_rdata_i(rdata2), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .rs1_data_o(rs1_o), .rs2_data_o(rs2_o), .imm_o(imm_o), .reg_waddr_o(waddr_o),
        .reg_we_o(we_o), .alu_op_o(alu_o), .alu_src1_pc_o(src1pc_o), .alu_src2_imm_o(src2imm_o),
        .mem_re_o(mre_o), .mem_we_o(mwe_o), .mem_size_o(msize_o), .branch_o(br_o),
        .jump_o(jmp_o), .illegal_o(ill_o)
    );

    // RV32E instance, exercised only by a few directed decodes.
    logic        e_valid, e_ready, e_out_valid, e_we, e_s1, e_s2, e_mre, e_mwe, e_br, e_jmp, e_ill;
    logic [31:0] e_inst, e_rdata1, e_rdata2, e_inst_o, e_addr_o, e_rs1, e_rs2, e_imm;
    logic [3:0]  e_raddr1, e_raddr2, e_waddr, e_alu;
    logic [2:0]  e_msize;

    assign e_rdata1 = regs[{1'b0, e_raddr1}];
    assign e_rdata2 = regs[{1'b0, e_raddr2}];

    ysyx_25060170_idu_stage #(.XLEN(32), .REG_AW(4), .ALU_OP_W(4)) dut_e (
        .clk(clk), .rst(rst), .in_valid_i(e_valid), .in_ready_o(e_ready), .inst_i(e_inst),
        .inst_addr_i(32'h0), .flush_i(1'b0), .reg1_raddr_o(e_raddr1), .reg2_raddr_o(e_raddr2),
        .reg1_rdata_i(e_rdata1), .reg2_rdata_i(e_rdata2), .out_valid_o(e_out_valid),
        .out_ready_i(1'b1), .inst_o(e_inst_o), .inst_addr_o(e_addr_o), .rs1_data_o(e_rs1),
        .rs2_data_o(e_rs2), .imm_o(e_imm), .reg_waddr_o(e_waddr), .reg_we_o(e_we),
        .alu_op_o(e_alu), .alu_src1_pc_o(e_s1), .alu_src2_imm_o(e_s2), .mem_re_o(e_mre),
        .mem_we_o(e_mwe), .mem_size_o(e_msize), .branch_o(e_br), .jump_o(e_jmp),
        .illegal_o(e_ill)
    );

    typedef struct packed {
        logic [31:0] inst, pc, rs1, rs2, imm;
        logic [4:0]  waddr;
        logic        we;
        logic [3:0]  alu;
        logic        s1pc, s2imm, mre, mwe;
        logic [2:0]  msize;
        logic        br, jmp, ill;
    } obs_t;

    typedef struct {
        logic [31:0] w;
        logic [31:0] imm;
        logic        we;
        logic [4:0]  rd;
        logic        ill, mwe, s2i;
        logic [2:0]  msz;
    } vec_t;

    obs_t        q[$];
    vec_t        vecs[14];
    int          n_chk = 0, n_err = 0;
    logic [31:0] pc_ctr = 32'h8000_0000;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_b(input string nm, input obs_t got, input obs_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o = {inst_o, inst_addr_o, rs1_o, rs2_o, imm_o, waddr_o, we_o, alu_o, src1pc_o,
             src2imm_o, mre_o, mwe_o, msize_o, br_o, jmp_o, ill_o};
        return o;
    endfunction

    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'd0: return AluAdd;
            3'd1: return AluSll;
            3'd2: return AluSlt;
            3'd3: return AluSltu;
            3'd4: return AluXor;
            3'd5: return AluSrl;
            3'd6: return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    // Reference decode straight from the ISA rules, with operands read from the bench regfile.
    function automatic obs_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        obs_t e;
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        int rd = int'(w[11:7]), a = int'(w[19:15]), b = int'(w[24:20]);
        bit ok = 0, writes = 0;
        e = '0;
        e.inst = w; e.pc = pc;
        e.rs1 = (a == 0) ? 32'h0 : regs[a];
        e.rs2 = (b == 0) ? 32'h0 : regs[b];
        case (w[6:0])
            LUI:   begin ok = 1; writes = 1; e.imm = {w[31:12], 12'h0}; e.alu = AluPassB;
                         e.s2imm = 1; end
            AUIPC: begin ok = 1; writes = 1; e.imm = {w[31:12], 12'h0}; e.s1pc = 1;
                         e.s2imm = 1; end
            JAL:   begin ok = 1; writes = 1; e.jmp = 1; e.s1pc = 1;
                         e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
            JALR:  begin ok = (f3 == 0); writes = 1; e.jmp = 1; e.s1pc = 1;
                         e.imm = 32'($signed(w[31:20])); end
            BRANCH: begin
                ok = !(f3 == 2 || f3 == 3); e.br = 1;
                e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                e.alu = (f3 < 4) ? AluSub : ((f3 >= 6) ? AluSltu : AluSlt);
            end
            LOAD:  begin ok = (f3 != 3 && f3 < 6); writes = 1; e.mre = 1; e.s2imm = 1;
                         e.msize = f3; e.imm = 32'($signed(w[31:20])); end
            STORE: begin ok = (f3 < 3); e.mwe = 1; e.s2imm = 1; e.msize = f3;
                         e.imm = 32'($signed({w[31:25], w[11:7]})); end
            OP_IMM: begin
                writes = 1; e.s2imm = 1; e.imm = 32'($signed(w[31:20])); e.alu = base_alu(f3);
                if (f3 == 1) ok = (f7 == 0);
                else if (f3 == 5) begin ok = (f7 == 0 || f7 == 7'h20);
                    if (f7 == 7'h20) e.alu = AluSra; end
                else ok = 1;
            end
            OP: begin
                writes = 1; e.alu = base_alu(f3);
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                if (f7 == 7'h20) e.alu = (f3 == 0) ? AluSub : AluSra;
            end
            MISC_MEM: ok = (f3 == 0);
            SYSTEM:   ok = (w == 32'h0000_0073) || (w == 32'h0010_0073);
            default:  ok = 0;
        endcase
        if (!ok) begin
            e = '0; e.inst = w; e.pc = pc;
            e.rs1 = (a == 0) ? 32'h0 : regs[a];
            e.rs2 = (b == 0) ? 32'h0 : regs[b];
            e.ill = 1;
        end else if (writes && rd != 0) begin
            e.we = 1; e.waddr = w[11:7];
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [11] = '{OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC,
                                 SYSTEM, MISC_MEM};
        logic [6:0] f7;
        case ($urandom_range(0, 9))
            0: return $urandom();
            1: return $urandom_range(0, 1) ? 32'h0000_0073 : 32'h0010_0073;
            default: begin
                case ($urandom_range(0, 2))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    default: f7 = 7'($urandom());
                endcase
                return {f7, 5'($urandom()), 5'($urandom()), 3'($urandom()), 5'($urandom()),
                        ops[$urandom_range(0, 10)]};
            end
        endcase
    endfunction

    task automatic check_out();
        chk("valid_ready", {62'b0, out_valid, in_ready}, {62'b0, q.size() > 0, q.size() < 2});
        if (q.size() > 0) chk_b("bundle", dut_obs(), q[0]);
    endtask

    // One cycle: drive at the falling edge, advance the FIFO model, check at the next one.
    task automatic step(input bit v, input logic [31:0] w, input bit f, input bit r);
        bit acc, con;
        in_valid = v; inst = w; inst_addr = pc_ctr; flush = f; out_ready = r;
        #1;
        chk("raddr", {54'b0, raddr1, raddr2}, {54'b0, w[19:15], w[24:20]});
        acc = v && (q.size() < 2) && !f;
        con = (q.size() > 0) && r;
        if (f) q.delete();
        else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(w, pc_ctr));
        end
        if (acc) pc_ctr += 32'd4;
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic e_step(input logic [31:0] w, input logic exp_ill, input logic exp_we,
                          input logic [3:0] exp_rd);
        e_valid = 1'b1; e_inst = w;
        @(posedge clk);
        @(negedge clk);
        e_valid = 1'b0;
        chk("rv32e", {57'b0, e_out_valid, e_ill, e_we, e_waddr}, {57'b0, 1'b1, exp_ill, exp_we,
                                                                  exp_rd});
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; inst = 0; inst_addr = 0; flush = 0; out_ready = 0;
        e_valid = 0; e_inst = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i * 32'h0101;
        regs[0] = 32'hDEAD_BEEF;
        regs[2] = 32'd7;

        vecs[0]  = '{32'h0051_0093, 32'h0000_0005, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 3'd0};
        vecs[1]  = '{32'h1234_52B7, 32'h1234_5000, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 3'd0};
        vecs[2]  = '{32'hFE20_AE23, 32'hFFFF_FFFC, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 3'd2};
        vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[4]  = '{32'h0000_0073, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[5]  = '{32'h4020_81B3, 32'h0000_0000, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[6]  = '{32'h0220_81B3, 32'h0000_0000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[7]  = '{32'hFE20_8CE3, 32'hFFFF_FFF8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[8]  = '{32'h0100_00EF, 32'h0000_0010, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[9]  = '{32'h1234_5037, 32'h1234_5000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd0};
        vecs[10] = '{32'h0FF0_000F, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[11] = '{32'h4031_5093, 32'h0000_0403, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 3'd0};
        vecs[12] = '{32'h4031_1093, 32'h0000_0000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[13] = '{32'h0080_A203, 32'h0000_0008, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 3'd2};

        repeat (3) @(negedge clk);
        chk("reset_flags", {62'b0, out_valid, in_ready}, 64'b01);
        chk_b("reset_payload", dut_obs(), '0);
        rst = 1'b0;

        // Decode table, one instruction per cycle with the EXU always ready.
        for (int i = 0; i < 14; i++) begin
            step(1, vecs[i].w, 0, 1);
            chk($sformatf("vec%0d", i),
                {imm_o, 20'b0, we_o, waddr_o, ill_o, mwe_o, src2imm_o, msize_o},
                {vecs[i].imm, 20'b0, vecs[i].we, vecs[i].rd, vecs[i].ill, vecs[i].mwe,
                 vecs[i].s2i, vecs[i].msz});
            if (i == 0) chk("addi_rs1", {32'b0, rs1_o}, 64'd7);
        end
        step(0, 32'h0, 0, 1);

        // Back-pressure: third instruction waits, order A, B, C preserved.
        step(1, 32'h0010_0113, 0, 0);
        step(1, 32'h0020_0193, 0, 0);
        step(1, 32'h0030_0213, 0, 0);
        chk("bp_hold", {31'b0, in_ready, inst_o}, {31'b0, 1'b0, 32'h0010_0113});
        step(1, 32'h0030_0213, 0, 1);
        chk("bp_skid", {32'b0, inst_o}, {32'b0, 32'h0020_0193});
        step(1, 32'h0030_0213, 0, 1);
        chk("bp_third", {32'b0, inst_o}, {32'b0, 32'h0030_0213});
        step(0, 32'h0, 0, 1);

        // Flush with both entries full and a new instruction offered.
        step(1, 32'h0050_0293, 0, 0);
        step(1, 32'h0060_0313, 0, 0);
        step(1, 32'h0070_0393, 1, 0);
        chk("flush", {62'b0, out_valid, in_ready}, 64'b01);
        step(0, 32'h0, 0, 1);

        // Asynchronous reset while full.
        step(1, 32'h0080_0413, 0, 0);
        step(1, 32'h0090_0493, 0, 0);
        in_valid = 1'b1; inst = 32'h00A0_0513;
        #2 rst = 1'b1;
        #1 chk("async_rst", {62'b0, out_valid, in_ready}, 64'b01);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk_b("rst_payload", dut_obs(), '0);
        in_valid = 1'b0;

        // RV32E: registers above x15 are illegal.
        e_step(32'h0020_81B3, 1'b0, 1'b1, 4'd3);
        e_step(32'h0020_8833, 1'b1, 1'b0, 4'd0);
        e_step(32'h0028_81B3, 1'b1, 1'b0, 4'd0);

        // Random traffic against the FIFO/decode model.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 31)] = $urandom();
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
